// File: rtl/fb_paddle_writer_if.sv
// rtl/fb_paddle_writer_if.sv - pixel RAM write-port bundle
interface fb_paddle_writer_if #(
    parameter int AW = 17,
    parameter int DW = 3
);
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;

    modport master (output mem_px_addr, output mem_px_data, output px_wr);
    modport slave  (input  mem_px_addr, input  mem_px_data, input  px_wr);
endinterface

// File: rtl/fb_paddle_writer.sv
// rtl/fb_paddle_writer.sv - frame-buffer clear, paddle draw and tick-driven paddle motion
module fb_paddle_writer #(
    parameter int            SCREEN_X    = 265,
    parameter int            SCREEN_Y    = 265,
    parameter int            AW          = 17,
    parameter int            DW          = 3,
    parameter int            BOX_W       = 16,
    parameter int            BOX_H       = 16,
    parameter int            BOX_Y       = 240,
    parameter int            BOX_X0      = 124,
    parameter int            STEP        = 4,
    parameter logic [DW-1:0] BG_COLOR    = 3'b000,
    parameter logic [DW-1:0] FG_COLOR    = 3'b100,
    parameter int            TICK_CYCLES = 416667
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in1,
    input  logic                in2,
    fb_paddle_writer_if.master  wr,
    output logic                busy
);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW = $clog2(BOX_W + 1);
    localparam int RW = $clog2(BOX_H + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(SCREEN_X * SCREEN_Y - 1);
    // Top-row base is an elaboration-time constant; per-row bases are accumulated.
    localparam logic [AW-1:0] ROW0      = AW'(BOX_Y * SCREEN_X);
    localparam logic [AW-1:0] STRIDE    = AW'(SCREEN_X);
    localparam logic [AW-1:0] X_MAX     = AW'(SCREEN_X - BOX_W);
    localparam logic [AW-1:0] STEP_A    = AW'(STEP);
    localparam logic [AW-1:0] X_INIT    = AW'(BOX_X0);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(BOX_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(BOX_H - 1);

    typedef enum logic [1:0] {CLEAR, DRAW, IDLE, ERASE} state_t;

    state_t        state;
    logic [AW-1:0] x;
    logic [AW-1:0] old_x;
    logic [AW-1:0] nx;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] row_base;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [TW-1:0] tick_cnt;
    logic          tick_pending;
    logic          consume;
    logic          in1_q1, in1_q2, in2_q1, in2_q2;

    // Two-flop synchronizers for the asynchronous push buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1_q1 <= 1'b0;
            in1_q2 <= 1'b0;
            in2_q1 <= 1'b0;
            in2_q2 <= 1'b0;
        end else begin
            in1_q1 <= in1;
            in1_q2 <= in1_q1;
            in2_q1 <= in2;
            in2_q2 <= in2_q1;
        end
    end

    assign consume = (state == IDLE) && tick_pending;

    // Free-running tick divider with a one-deep pending flag; extra ticks are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt     <= '0;
            tick_pending <= 1'b0;
        end else begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt     <= '0;
                tick_pending <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
                if (consume) begin
                    tick_pending <= 1'b0;
                end
            end
        end
    end

    // Next paddle column from the synchronized buttons, clamped to the screen.
    always_comb begin
        nx = x;
        if (in1_q2 && !in2_q2) begin
            nx = (x + STEP_A > X_MAX) ? X_MAX : x + STEP_A;
        end else if (!in1_q2 && in2_q2) begin
            nx = (x < STEP_A) ? '0 : x - STEP_A;
        end
    end

    // Main sequencer: clear, draw, wait for a tick, erase old paddle, redraw.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= CLEAR;
            x              <= X_INIT;
            old_x          <= X_INIT;
            clr_addr       <= '0;
            row_base       <= ROW0;
            col            <= '0;
            row            <= '0;
            wr.px_wr       <= 1'b0;
            wr.mem_px_addr <= '0;
            wr.mem_px_data <= BG_COLOR;
            busy           <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    wr.px_wr       <= 1'b1;
                    wr.mem_px_addr <= clr_addr;
                    wr.mem_px_data <= BG_COLOR;
                    busy           <= 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr <= '0;
                        col      <= '0;
                        row      <= '0;
                        row_base <= ROW0;
                        state    <= DRAW;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                DRAW, ERASE: begin
                    wr.px_wr       <= 1'b1;
                    busy           <= 1'b1;
                    wr.mem_px_addr <= row_base + ((state == DRAW) ? x : old_x) + AW'(col);
                    wr.mem_px_data <= (state == DRAW) ? FG_COLOR : BG_COLOR;
                    if (col == COL_LAST) begin
                        col      <= '0;
                        row_base <= row_base + STRIDE;
                        if (row == ROW_LAST) begin
                            row      <= '0;
                            row_base <= ROW0;
                            state    <= (state == DRAW) ? IDLE : DRAW;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                IDLE: begin
                    wr.px_wr <= 1'b0;
                    busy     <= 1'b0;
                    if (tick_pending && (nx != x)) begin
                        old_x <= x;
                        x     <= nx;
                        busy  <= 1'b1;
                        state <= ERASE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_paddle_writer.sv
// tb/tb_fb_paddle_writer.sv - directed self-checking bench for fb_paddle_writer
module tb_fb_paddle_writer;
    localparam int SX   = 40;
    localparam int SY   = 30;
    localparam int AW   = 11;
    localparam int DW   = 3;
    localparam int BW   = 5;
    localparam int BH   = 3;
    localparam int BY   = 20;
    localparam int X0   = 10;
    localparam int ST   = 4;
    localparam int TICK = 20;
    localparam logic [DW-1:0] BG = 3'b001;
    localparam logic [DW-1:0] FG = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in1 = 1'b0;
    logic in2 = 1'b0;
    logic busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fb_paddle_writer_if #(.AW(AW), .DW(DW)) ram_if ();

    fb_paddle_writer #(
        .SCREEN_X(SX), .SCREEN_Y(SY), .AW(AW), .DW(DW),
        .BOX_W(BW), .BOX_H(BH), .BOX_Y(BY), .BOX_X0(X0), .STEP(ST),
        .BG_COLOR(BG), .FG_COLOR(FG), .TICK_CYCLES(TICK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in1(in1),
        .in2(in2),
        .wr(ram_if),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Full-screen clear; entry sample is the first clear write.
    task automatic clear_run(input string tag);
        int bad = 0;
        logic [31:0] last_a;
        for (int i = 0; i < SX * SY; i++) begin
            if (i > 0) step();
            if (ram_if.px_wr !== 1'b1 || ram_if.mem_px_data !== BG || busy !== 1'b1 ||
                32'(ram_if.mem_px_addr) !== 32'(i))
                bad++;
        end
        last_a = 32'(ram_if.mem_px_addr);
        chk({tag, " bad cycles"}, 32'(bad), 32'd0);
        chk({tag, " last addr"}, last_a, 32'(SX * SY - 1));
    endtask

    // Rectangle of BW*BH writes at column x; entry sample is its first write.
    task automatic rect(input int x, input logic [DW-1:0] color, input string tag);
        int bad_w = 0;
        int bad_a = 0;
        int bad_d = 0;
        logic [31:0] first_a;
        logic [31:0] e;
        first_a = 32'(ram_if.mem_px_addr);
        for (int i = 0; i < BW * BH; i++) begin
            if (i > 0) step();
            e = 32'(BY * SX + (i / BW) * SX + x + (i % BW));
            if (ram_if.px_wr !== 1'b1) bad_w++;
            if (32'(ram_if.mem_px_addr) !== e) bad_a++;
            if (ram_if.mem_px_data !== color) bad_d++;
        end
        chk({tag, " first addr"}, first_a, 32'(BY * SX + x));
        chk({tag, " last addr"}, 32'(ram_if.mem_px_addr), 32'(BY * SX + (BH - 1) * SX + x + BW - 1));
        chk({tag, " wr gaps"}, 32'(bad_w), 32'd0);
        chk({tag, " addr errs"}, 32'(bad_a), 32'd0);
        chk({tag, " data errs"}, 32'(bad_d), 32'd0);
    endtask

    task automatic move(input int ox, input int nx, input bit rel, input bit chained, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (ram_if.px_wr !== 1'b1 && n < 200);
        chk({tag, " start"}, 32'(ram_if.px_wr), 32'd1);
        if (chained) chk({tag, " idle gap"}, 32'(n), 32'd2);
        if (rel) begin
            in1 = 1'b0;
            in2 = 1'b0;
        end
        rect(ox, BG, {tag, " erase"});
        step();
        rect(nx, FG, {tag, " draw"});
    endtask

    task automatic quiet(input int n, input string tag);
        int w = 0;
        int b = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (ram_if.px_wr !== 1'b0) w++;
            if (busy !== 1'b0) b++;
        end
        chk({tag, " writes"}, 32'(w), 32'd0);
        chk({tag, " busy"}, 32'(b), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held three cycles.
        repeat (3) step();
        chk("reset px_wr", 32'(ram_if.px_wr), 32'd0);
        chk("reset addr", 32'(ram_if.mem_px_addr), 32'd0);
        chk("reset data", 32'(ram_if.mem_px_data), 32'(BG));
        chk("reset busy", 32'(busy), 32'd1);

        // First edge after release writes address 0.
        rst = 1'b1;
        step();
        chk("first write px_wr", 32'(ram_if.px_wr), 32'd1);
        chk("first write addr", 32'(ram_if.mem_px_addr), 32'd0);
        clear_run("power-up clear");
        step();
        rect(X0, FG, "power-up draw");
        step();
        chk("after draw px_wr", 32'(ram_if.px_wr), 32'd0);
        chk("after draw busy", 32'(busy), 32'd0);
        quiet(100, "no buttons");

        // Both buttons pressed: no motion.
        in1 = 1'b1;
        in2 = 1'b1;
        quiet(100, "both buttons");
        in1 = 1'b0;
        in2 = 1'b0;

        // Left moves down to the clamp at column 0.
        in2 = 1'b1;
        move(10, 6, 1'b0, 1'b0, "left 10-6");
        move(6, 2, 1'b0, 1'b1, "left 6-2");
        move(2, 0, 1'b1, 1'b1, "left clamp 2-0");
        quiet(100, "after left release");
        in2 = 1'b1;
        quiet(100, "left at 0");
        in2 = 1'b0;

        // Right moves up to the clamp at SX-BW = 35.
        in1 = 1'b1;
        move(0, 4, 1'b0, 1'b0, "right 0-4");
        for (int x = 4; x < 32; x += 4) move(x, x + 4, 1'b0, 1'b1, "right step");
        move(32, 35, 1'b0, 1'b1, "right clamp 32-35");
        quiet(100, "right at 35");
        in1 = 1'b0;

        // Button held across ticks that land while busy, released on the second move.
        in2 = 1'b1;
        move(35, 31, 1'b0, 1'b0, "busy tick 35-31");
        move(31, 27, 1'b1, 1'b1, "busy tick 31-27");
        quiet(100, "after busy ticks");

        // Reset in the middle of an erase.
        in1 = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (ram_if.px_wr !== 1'b1 && n < 200);
        chk("mid-erase start", 32'(ram_if.px_wr), 32'd1);
        repeat (7) step();
        rst = 1'b0;
        #1;
        chk("async reset px_wr", 32'(ram_if.px_wr), 32'd0);
        chk("async reset addr", 32'(ram_if.mem_px_addr), 32'd0);
        chk("async reset busy", 32'(busy), 32'd1);
        in1 = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("restart px_wr", 32'(ram_if.px_wr), 32'd1);
        chk("restart addr", 32'(ram_if.mem_px_addr), 32'd0);
        clear_run("restart clear");
        step();
        rect(X0, FG, "restart draw");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
